// File: rtl/inst_mem.sv
// Banked instruction memory with a streaming loader and a 1-cycle registered fetch port.
// A bank being loaded is locked against fetch; every other bank stays readable.
module inst_mem #(
   parameter  int IW = 8,
   parameter  int DW = 9,
   parameter  int NB = 2,
   localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic          LoadStart,
   input  logic [BW-1:0] LoadBank,
   input  logic          LoadValid,
   input  logic [DW-1:0] LoadData,
   input  logic          LoadLast,
   output logic          LoadReady,
   output logic          LoadDone,
   output logic          Busy,
   input  logic [BW-1:0] BankSel,
   input  logic          FetchReq,
   input  logic [IW-1:0] InstAddress,
   output logic [DW-1:0] InstOut,
   output logic          InstValid
);

   localparam int DEPTH = NB << IW;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [BW-1:0] bank_q, bank_d;
   logic          done_q, done_d;
   logic          we;
   logic          load_bank_ok;
   logic          fetch_ok;
   logic [DW-1:0] inst_q;
   logic          ival_q;

   // Storage is never reset so a reload can leave the tail of a bank intact.
   logic [DW-1:0] mem [DEPTH];

   assign load_bank_ok = (int'(LoadBank) < NB);
   assign fetch_ok     = FetchReq && (int'(BankSel) < NB) &&
                         !((state_q == LOAD) && (BankSel == bank_q));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bank_d  = bank_q;
      done_d  = 1'b0;
      we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (LoadStart && load_bank_ok) begin
               state_d = LOAD;
               ptr_d   = '0;
               bank_d  = LoadBank;
            end
         end
         LOAD: begin
            if (LoadValid) begin
               we = 1'b1;
               // The last address terminates the load; the pointer never wraps.
               if (LoadLast || (ptr_q == {IW{1'b1}})) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         bank_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bank_q  <= bank_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[{bank_q, ptr_q}] <= LoadData;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         inst_q <= '0;
         ival_q <= 1'b0;
      end else begin
         ival_q <= fetch_ok;
         if (fetch_ok) begin
            inst_q <= mem[{BankSel, InstAddress}];
         end
      end
   end

   assign Busy      = (state_q == LOAD);
   assign LoadReady = (state_q == LOAD);
   assign LoadDone  = done_q;
   assign InstOut   = inst_q;
   assign InstValid = ival_q;

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter IW, default 8: address width; each bank holds 2**IW words.
REQ-002 Parameter DW, default 9: instruction word width.
REQ-003 Parameter NB, default 2: number of program banks; BW = max(1, clog2(NB)).
REQ-004 CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 LoadStart  in  1  one-cycle request to begin loading bank LoadBank from word 0.
REQ-007 LoadBank  in  BW  target bank, sampled when LoadStart is accepted.
REQ-008 LoadValid  in  1  LoadData holds a valid word.
REQ-009 LoadData  in  DW  word to write.
REQ-010 LoadLast  in  1  qualifies LoadValid; marks the final word of the load.
REQ-011 LoadReady  out  1  loader accepts a word this cycle.
REQ-012 LoadDone  out  1  one-cycle pulse, load completed.
REQ-013 Busy  out  1  high while a load is in progress.
REQ-014 BankSel  in  BW  bank used for fetch.
REQ-015 FetchReq  in  1  fetch request for InstAddress.
REQ-016 InstAddress  in  IW  fetch word address.
REQ-017 InstOut  out  DW  registered fetched word.
REQ-018 InstValid  out  1  InstOut updated by the fetch issued the previous cycle.

Function
REQ-019 Storage SHALL be NB x 2**IW words of DW bits; the array SHALL NOT be cleared by reset.
REQ-020 FSM SHALL have states IDLE and LOAD; Busy and LoadReady SHALL equal (state==LOAD).
REQ-021 IDLE->LOAD SHALL occur when LoadStart=1 and LoadBank<NB; write pointer SHALL clear to 0 and the bank latch SHALL capture LoadBank.
REQ-022 LoadStart with LoadBank>=NB SHALL be ignored; LoadStart in LOAD SHALL be ignored.
REQ-023 In LOAD, each cycle with LoadValid=1 SHALL write LoadData to latched bank at pointer, then increment the pointer.
REQ-024 Accepted word with LoadLast=1, or pointer at 2**IW-1, SHALL return to IDLE and pulse LoadDone exactly one cycle later; words beyond the last written SHALL keep prior contents.
REQ-025 Pointer SHALL NOT wrap; the final address ends the load regardless of LoadLast.
REQ-026 Fetch latency SHALL be 1 cycle: FetchReq=1 at edge N SHALL yield InstOut=mem[BankSel][InstAddress] and InstValid=1 after edge N.
REQ-027 FetchReq=0 SHALL leave InstOut unchanged and set InstValid=0.
REQ-028 Fetch while Busy=1 and BankSel equals the latched load bank SHALL be blocked: InstOut unchanged, InstValid=0.
REQ-029 Fetch from any other bank during LOAD SHALL proceed normally, concurrently with writes.
REQ-030 BankSel>=NB SHALL be treated as blocked (InstValid=0, InstOut unchanged).
REQ-031 A write accepted in the same cycle as a LoadStart-to-IDLE transition SHALL not occur (no write in IDLE).

Reset
REQ-032 Reset_n=0 SHALL immediately force state IDLE, pointer 0, InstOut 0, InstValid 0, LoadDone 0, LoadReady 0, Busy 0.
REQ-033 Reset mid-load SHALL abort without LoadDone; already-written words SHALL remain.
REQ-034 After Reset_n deasserts, the first LoadStart or FetchReq SHALL be honoured on the next rising edge.

Verification (IW=4, DW=9, NB=2)
REQ-035 Load bank 0 with 16 words 9'h100+i, LoadLast=0 -> LoadDone pulse one cycle after word 15, Busy falls; fetch addr 5 bank 0 -> InstOut=9'h105, InstValid=1 next cycle.
REQ-036 Load bank 1 words 9'h0AA,9'h0BB with LoadLast on word 1 -> LoadDone after word 1; addr 2 bank 1 retains prior value.
REQ-037 During bank 1 load, fetch bank 0 addr 3 -> valid previously loaded word; fetch bank 1 -> InstValid=0, InstOut unchanged.
REQ-038 LoadValid gaps (valid every third cycle) -> pointer advances only on valid cycles; contents match sequence.
REQ-039 Reset_n low after 4 words of a bank 0 reload -> outputs 0 asynchronously, no LoadDone; addrs 0-3 new, 4-15 old.
REQ-040 LoadStart with LoadBank=1 while in LOAD, and BankSel=3 fetch (BW=1 masks; with NB=3 use BankSel=3) -> ignored / InstValid=0.
